// File: rtl/i2c_oled_target.sv
// Receive-only I2C target for the SSD1306 write path: decodes START/STOP, ACKs address/control/data bytes and strobes payload bytes with their D/C# tag.
// Optional `define I2C_TARGET_GLITCH_FILTER_EN inserts a 3-sample majority filter after each synchronizer.
module i2c_oled_target #(
  parameter logic [6:0] ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_is_data,
  output logic [9:0] byte_count,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_CTRL, S_CTRL_ACK,
    S_DATA_ONE, S_DATA_STREAM, S_DATA_ACK, S_IGNORE
  } state_t;

  state_t      state, state_next;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_f, sda_f, scl_q, sda_q;
  logic        scl_rise, scl_fall, start_ev, stop_ev;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        co, dc, pend, sda_oe;
  logic        collect, payload, ack_next, byte_end, addr_hit;

  // Synchronizers reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_f    <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
      sda_f    <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
    end
  end
`else
  always_comb begin
    scl_f = scl_sync[1];
    sda_f = sda_sync[1];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  always_comb begin
    scl_rise = scl_f & ~scl_q;
    scl_fall = ~scl_f & scl_q;
    start_ev = scl_f & scl_q & sda_q & ~sda_f;
    stop_ev  = scl_f & scl_q & ~sda_q & sda_f;
    collect  = state inside {S_ADDR, S_CTRL, S_DATA_ONE, S_DATA_STREAM};
    payload  = state inside {S_DATA_ONE, S_DATA_STREAM};
    byte_end = scl_fall && (bit_cnt == 4'd8);
    addr_hit = (shreg[7:1] == ADDR) && !shreg[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start_ev) begin
      state_next = S_ADDR;
    end else if (stop_ev) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_ADDR:        if (byte_end) state_next = addr_hit ? S_ADDR_ACK : S_IGNORE;
        S_CTRL:        if (byte_end) state_next = S_CTRL_ACK;
        S_DATA_ONE,
        S_DATA_STREAM: if (byte_end) state_next = S_DATA_ACK;
        S_ADDR_ACK:    if (scl_fall) state_next = S_CTRL;
        S_CTRL_ACK:    if (scl_fall) state_next = co ? S_DATA_ONE : S_DATA_STREAM;
        S_DATA_ACK:    if (scl_fall) state_next = co ? S_CTRL : S_DATA_STREAM;
        default:       ;
      endcase
    end
    ack_next = state_next inside {S_ADDR_ACK, S_CTRL_ACK, S_DATA_ACK};
  end

  // sda_oe follows the next state, so START/STOP release the bus in the same cycle they are flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_oe       <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      co           <= 1'b0;
      dc           <= 1'b0;
      pend         <= 1'b0;
      byte_data    <= '0;
      byte_valid   <= 1'b0;
      byte_is_data <= 1'b0;
      byte_count   <= '0;
      busy         <= 1'b0;
      start_det    <= 1'b0;
      stop_det     <= 1'b0;
    end else begin
      start_det  <= start_ev;
      stop_det   <= stop_ev;
      sda_oe     <= ack_next;
      pend       <= 1'b0;
      byte_valid <= pend;
      if (start_ev) begin
        bit_cnt    <= '0;
        byte_count <= '0;
      end else if (!stop_ev) begin
        if (collect && scl_rise && (bit_cnt != 4'd8)) begin
          shreg   <= {shreg[6:0], sda_f};
          bit_cnt <= bit_cnt + 4'd1;
          pend    <= payload && (bit_cnt == 4'd7);
        end
        if (!collect && scl_fall) bit_cnt <= '0;
        if (state == S_CTRL && state_next == S_CTRL_ACK) begin
          co <= shreg[7];
          dc <= shreg[6];
        end
        if (pend) begin
          byte_data    <= shreg;
          byte_is_data <= dc;
          byte_count   <= byte_count + 10'd1;
        end
      end
      if (stop_ev)                                         busy <= 1'b0;
      else if (state == S_ADDR && state_next == S_ADDR_ACK) busy <= 1'b1;
      else if (state_next == S_IGNORE)                     busy <= 1'b0;
    end
  end

  assign sda = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: doc/i2c_oled_target.md
# i2c_oled_target

Receive-only I2C target (responder) at the far end of the OLED write path. Decodes START/STOP, matches a 7-bit address, ACKs the address, control and data bytes, and follows SSD1306 control-byte semantics (Co, D/C#). Each received payload byte is presented on a one-cycle strobe with its command/data tag. It serves as a bench model of the panel and as an in-fabric bus monitor for the write path.

## Interface
- ADDR, 7'h3C, target address to respond to.
- clk  input  1  system clock; SCL/SDA are oversampled by it (at least 16x SCL).
- rst_n  input  1  reset, asynchronous, active-low.
- scl  input  1  I2C clock, sampled only; never driven.
- sda  inout  1  I2C data, open-drain: driven 0 during ACK slots, otherwise 1'bz.
- byte_data  output  8  last received payload byte.
- byte_valid  output  1  one-cycle strobe; byte_data, byte_is_data and byte_count are valid this cycle.
- byte_is_data  output  1  D/C# in force for this byte: 1 = GDDRAM data, 0 = command.
- byte_count  output  10  payload bytes ACKed since the last START.
- busy  output  1  high from an address match until STOP or NACK-idle.
- start_det  output  1  one-cycle pulse for each START or repeated START.
- stop_det  output  1  one-cycle pulse for each STOP.

## Operation
- Input path: scl and sda each pass through a 2-FF synchronizer, then edge detection on the synchronized values.
- START: sda falls while scl is high. START from any state → ADDR with the bit counter cleared and byte_count cleared.
- STOP: sda rises while scl is high. STOP from any state → IDLE, sda released.
- Sampling: data bits are taken on the scl rising edge, MSB first. The bit counter advances on scl rising edges.
- States:
  - IDLE: waits for START.
  - ADDR: collects 8 bits (7 address bits plus R/W).
  - ADDR_ACK: entered on the scl falling edge after bit 8.
    - Address matches and R/W=0: drive sda low, set busy.
    - Otherwise: leave sda released (NACK) and go to IGNORE.
  - CTRL: collects the control byte. Latches Co = bit7 and DC = bit6. Then CTRL_ACK (drives ACK).
  - After CTRL_ACK: Co=1 → DATA_ONE; Co=0 → DATA_STREAM.
  - DATA_ONE: one payload byte, ACK, then back to CTRL.
  - DATA_STREAM: payload bytes, each ACKed, until STOP or repeated START.
  - IGNORE: sda released; waits for STOP or START.
- ACK slot timing: sda_oe is set on the scl falling edge that ends bit 8. It is cleared on the next scl falling edge, which ends the 9th clock.
- Payload byte strobe: byte_valid pulses on the clk after the 8th bit of a DATA_ONE or DATA_STREAM byte is sampled. byte_is_data = latched DC at that time.
- byte_count increments with each byte_valid. It wraps 1023 → 0 and is cleared on START.
- Control bytes never produce byte_valid.

## Timing
- Reset values: all outputs 0, state IDLE, sda released (1'bz), DC=0, Co=0.
- Latency:
  - Bus edge to detection: 3 clk (2 sync + 1 edge register).
  - byte_valid: 4 clk after the scl rising edge of bit 8.
- ACK drive: sda is pulled low 3–4 clk after scl falls. This is well inside SCL low for clk ≥ 16x SCL. Setup before the next scl rise must be at least 4 clk.
- Simultaneous events: START/STOP detection takes priority over bit sampling in the same cycle. A scl edge is never coincident with a START/STOP-defining sda edge after sync.
- Missing 9th clock (STOP arrives during an ACK slot): sda is released in the same cycle stop_det pulses.
- Reset mid-operation: sda releases immediately (asynchronous). The first event honoured after release is START.
- Address mismatch: no outputs toggle except start_det and stop_det.

## Configuration
- Macro I2C_TARGET_GLITCH_FILTER_EN defined:
  - A 3-sample majority filter sits after each synchronizer.
  - Pulses of 1 clk are rejected.
  - All latencies above grow by 2 clk (detection 5 clk, byte_valid 6 clk, ACK drive 5–6 clk).
- Undefined: no filter; latencies as stated.

## Test plan
- Reset then single write: START, 0x78, 0x00, 0xAE, STOP → three ACKs; byte_valid once with byte_data=0xAE, byte_is_data=0, byte_count=1; stop_det pulses.
- Data stream: 0x78, 0x40, 0x11, 0x22, 0x33 → three strobes with byte_is_data=1; byte_count 1,2,3; sda low only in the ACK slots.
- Co=1 alternation: 0x78, 0x80, 0xA5, 0xC0, 0x5A → 0xA5 strobed as a command, 0x5A strobed as data; control bytes are not strobed.
- Wrong address 0x7A or read 0x79 → sda never driven (NACK); busy stays 0; no byte_valid until the next START.
- Stream of 1025 data bytes → byte_count wraps to 0 at byte 1024 and reads 1 at byte 1025. A repeated START mid-stream clears byte_count and re-enters ADDR.
- rst_n asserted during a data ACK slot → sda is Z in the same cycle; outputs return to 0; the next transaction is received correctly.
